// File: rtl/alu_rvs_pkg.sv
// Shared opcode and funct encodings for the bit-reverse issue stage.
// Decode maps legal opcodes straight to funct; anything above rev16 is tagged illegal.
package alu_rvs_pkg;

  localparam logic [3:0]  OP_PASS        = 4'd0;
  localparam logic [3:0]  OP_REV2        = 4'd1;
  localparam logic [3:0]  OP_REV4        = 4'd2;
  localparam logic [3:0]  OP_REV8        = 4'd3;
  localparam logic [3:0]  OP_REV16       = 4'd4;
  localparam logic [2:0]  FUNCT_ILLEGAL  = 3'b111;
  localparam logic [31:0] ILLEGAL_RESULT = 32'hDEAD_BEEF;

  typedef struct packed {
    logic       illegal;
    logic [2:0] funct;
  } dec_t;

  function automatic dec_t decode_op(input logic [3:0] op);
    dec_t d;
    if (op <= OP_REV16) begin
      d.illegal = 1'b0;
      d.funct   = op[2:0];
    end else begin
      d.illegal = 1'b1;
      d.funct   = FUNCT_ILLEGAL;
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_rvs_fifo.sv
// Generic DEPTH x W synchronous FIFO with flush, full/empty and occupancy count.
// Head data is read straight from storage, so it stays put until a pop.
module alu_rvs_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Flush re-aligns the read pointer to the write pointer without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_rvs_issue.sv
// Registered issue stage feeding the combinational bit-reverse unit.
// Optional statistics (accept_cnt, stall_cnt) are built when ALU_RVS_ISSUE_STATS_EN is defined.
import alu_rvs_pkg::*;

module alu_rvs_issue #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [3:0]       s_op,
  input  logic [31:0]      s_data,
  input  logic [TAG_W-1:0] s_tag,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_din,
  output logic [2:0]       m_funct,
  output logic [TAG_W-1:0] m_tag,
  output logic             m_illegal,
  output logic [CNT_W-1:0] illegal_cnt
`ifdef ALU_RVS_ISSUE_STATS_EN
  ,
  output logic [CNT_W-1:0] accept_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam int EW = 1 + 3 + TAG_W + 32;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  dec_t                    dec;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic [EW-1:0]           wdata;
  logic [EW-1:0]           rdata;
  logic [$clog2(DEPTH):0]  occupancy_unused;

  assign dec     = decode_op(s_op);
  assign wdata   = {dec.illegal, dec.funct, s_tag, s_data};
  assign s_ready = !full;
  assign m_valid = !empty;
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;
  assign {m_illegal, m_funct, m_tag, m_din} = rdata;

  alu_rvs_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (occupancy_unused)
  );

  // A push dropped by flush never counts as an accepted illegal op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (push && !flush && dec.illegal && (illegal_cnt != '1)) begin
      illegal_cnt <= illegal_cnt + CNT_ONE;
    end
  end

`ifdef ALU_RVS_ISSUE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (push && !flush && (accept_cnt != '1)) accept_cnt <= accept_cnt + CNT_ONE;
      if (m_valid && !m_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_alu_rvs_issue.sv
// Scoreboard bench for alu_rvs_issue: stimulus queues expected entries, a monitor pops on each handshake.
// Stats ports are connected when ALU_RVS_ISSUE_STATS_EN is defined.
module tb_alu_rvs_issue;
  import alu_rvs_pkg::*;

  localparam int DEPTH = 2;
  localparam int TAG_W = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [3:0]       s_op = '0;
  logic [31:0]      s_data = '0;
  logic [TAG_W-1:0] s_tag = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [31:0]      m_din;
  logic [2:0]       m_funct;
  logic [TAG_W-1:0] m_tag;
  logic             m_illegal;
  logic [CNT_W-1:0] illegal_cnt;
`ifdef ALU_RVS_ISSUE_STATS_EN
  logic [CNT_W-1:0] accept_cnt;
  logic [CNT_W-1:0] stall_cnt;
`endif

  typedef struct {
    logic [31:0]      din;
    logic [2:0]       funct;
    logic [TAG_W-1:0] tag;
    logic             illegal;
    logic [31:0]      res;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   pops  = 0;

  alu_rvs_issue #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_op        (s_op),
    .s_data      (s_data),
    .s_tag       (s_tag),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_din       (m_din),
    .m_funct     (m_funct),
    .m_tag       (m_tag),
    .m_illegal   (m_illegal),
    .illegal_cnt (illegal_cnt)
`ifdef ALU_RVS_ISSUE_STATS_EN
    ,
    .accept_cnt  (accept_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the downstream reverse unit.
  function automatic logic [31:0] rev_unit(input logic [31:0] x, input logic [2:0] f);
    logic [31:0] y;
    int g;
    if (f > 3'd4) return ILLEGAL_RESULT;
    g = 1 << f;
    for (int i = 0; i < 32; i++) y[i] = x[(i / g) * g + (g - 1 - (i % g))];
    return y;
  endfunction

  function automatic exp_t mk(input logic [31:0] din, input logic [2:0] funct,
                              input logic [TAG_W-1:0] tag, input logic illegal,
                              input logic [31:0] res);
    exp_t e;
    e.din = din; e.funct = funct; e.tag = tag; e.illegal = illegal; e.res = res;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] data,
                               input logic [TAG_W-1:0] tag, input exp_t e,
                               input bit expect_accept);
    bit accepted;
    s_valid = 1'b1; s_op = op; s_data = data; s_tag = tag;
    @(negedge clk);
    accepted = s_ready && !flush;
    checkOutput("accept", 32'(accepted), 32'(expect_accept));
    @(posedge clk); #1;
    if (accepted) sb.push_back(e);
    s_valid = 1'b0;
  endtask

  // Monitor: every completed handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready && !flush) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_out: got=%h want=none", m_din);
      end else begin
        exp_t e;
        e = sb.pop_front();
        pops++;
        checkOutput("out_din",     m_din,                     e.din);
        checkOutput("out_funct",   32'(m_funct),              32'(e.funct));
        checkOutput("out_tag",     32'(m_tag),                32'(e.tag));
        checkOutput("out_illegal", 32'(m_illegal),            32'(e.illegal));
        checkOutput("out_res",     rev_unit(m_din, m_funct),  e.res);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    checkOutput("rst_mvalid",  32'(m_valid),     32'd0);
    checkOutput("rst_sready",  32'(s_ready),     32'd1);
    checkOutput("rst_din",     m_din,            32'd0);
    checkOutput("rst_funct",   32'(m_funct),     32'd0);
    checkOutput("rst_tag",     32'(m_tag),       32'd0);
    checkOutput("rst_illegal", 32'(m_illegal),   32'd0);
    checkOutput("rst_icnt",    32'(illegal_cnt), 32'd0);
`ifdef ALU_RVS_ISSUE_STATS_EN
    checkOutput("rst_acnt",    32'(accept_cnt),  32'd0);
    checkOutput("rst_scnt",    32'(stall_cnt),   32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // rev8 with one-cycle latency, then an illegal op
    m_ready = 1'b1;
    applyStimulus(OP_REV8, 32'h0102_0304, 4'd5, mk(32'h0102_0304, 3'd3, 4'd5, 1'b0, 32'h8040_C020), 1'b1);
    checkOutput("latency_mvalid", 32'(m_valid), 32'd1);
    applyStimulus(4'd9, 32'h1234_5678, 4'd2, mk(32'h1234_5678, 3'd7, 4'd2, 1'b1, 32'hDEAD_BEEF), 1'b1);
    checkOutput("illegal_cnt1", 32'(illegal_cnt), 32'd1);
    checkOutput("head_illegal", 32'(m_illegal),   32'd1);
    checkOutput("head_funct",   32'(m_funct),     32'd7);
    @(posedge clk); #1;

    // Fill to DEPTH with the consumer stalled, then drain
    m_ready = 1'b0;
    applyStimulus(OP_REV2, 32'hAAAA_5555, 4'd1, mk(32'hAAAA_5555, 3'd1, 4'd1, 1'b0, 32'h5555_AAAA), 1'b1);
    applyStimulus(OP_REV4, 32'h1234_5678, 4'd3, mk(32'h1234_5678, 3'd2, 4'd3, 1'b0, 32'h84C2_A6E1), 1'b1);
    checkOutput("full_sready", 32'(s_ready), 32'd0);
    applyStimulus(OP_REV16, 32'h0000_FFFF, 4'd7, mk(32'h0000_FFFF, 3'd4, 4'd7, 1'b0, 32'h0000_FFFF), 1'b0);
    m_ready = 1'b1;
    @(negedge clk);
    checkOutput("sready_during_pop", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    checkOutput("sready_after_pop", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    checkOutput("drained_mvalid", 32'(m_valid), 32'd0);

    // Occupancy 1, simultaneous push and pop streaming
    m_ready = 1'b0;
    applyStimulus(OP_REV16, 32'h0001_0003, 4'hE, mk(32'h0001_0003, 3'd4, 4'hE, 1'b0, 32'h8000_C000), 1'b1);
    m_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(OP_PASS, 32'h100 + 32'(i), 4'(i), mk(32'h100 + 32'(i), 3'd0, 4'(i), 1'b0, 32'h100 + 32'(i)), 1'b1);
      checkOutput("stream_mvalid", 32'(m_valid), 32'd1);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Flush while full with a concurrent request
    m_ready = 1'b0;
    applyStimulus(OP_PASS, 32'h0000_0011, 4'd1, mk(32'h11, 3'd0, 4'd1, 1'b0, 32'h11), 1'b1);
    applyStimulus(OP_PASS, 32'h0000_0022, 4'd2, mk(32'h22, 3'd0, 4'd2, 1'b0, 32'h22), 1'b1);
    s_valid = 1'b1; s_op = 4'd10; s_data = 32'h0BAD_0BAD; s_tag = 4'hF; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; s_valid = 1'b0;
    sb.delete();
    checkOutput("flush_mvalid", 32'(m_valid),     32'd0);
    checkOutput("flush_sready", 32'(s_ready),     32'd1);
    checkOutput("flush_icnt",   32'(illegal_cnt), 32'd1);

    // Flush at occupancy 1 where the illegal push would otherwise be accepted
    applyStimulus(OP_PASS, 32'h0000_0033, 4'd3, mk(32'h33, 3'd0, 4'd3, 1'b0, 32'h33), 1'b1);
    s_valid = 1'b1; s_op = 4'd12; s_data = 32'h0BAD_0C0C; s_tag = 4'hC; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; s_valid = 1'b0;
    sb.delete();
    checkOutput("flush1_mvalid", 32'(m_valid),     32'd0);
    checkOutput("flush1_icnt",   32'(illegal_cnt), 32'd1);
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post_flush_mvalid", 32'(m_valid), 32'd0);

    // Asynchronous reset with two entries buffered
    m_ready = 1'b0;
    applyStimulus(4'd15,  32'h0000_0055, 4'd9,  mk(32'h55, 3'd7, 4'd9,  1'b1, 32'hDEAD_BEEF), 1'b1);
    applyStimulus(OP_PASS, 32'h0000_0066, 4'd10, mk(32'h66, 3'd0, 4'd10, 1'b0, 32'h66), 1'b1);
    checkOutput("pre_rst_icnt",   32'(illegal_cnt), 32'd2);
    checkOutput("pre_rst_mvalid", 32'(m_valid),     32'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    checkOutput("async_rst_mvalid", 32'(m_valid),     32'd0);
    checkOutput("async_rst_sready", 32'(s_ready),     32'd1);
    checkOutput("async_rst_icnt",   32'(illegal_cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_mvalid", 32'(m_valid),     32'd0);
    checkOutput("post_rst_icnt",   32'(illegal_cnt), 32'd0);
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    checkOutput("sb_empty",  32'(sb.size()), 32'd0);
    checkOutput("pop_count", 32'(pops),      32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_rvs_issue.md
Name: alu_rvs_issue

Overview:
- Registered issue stage directly upstream of the combinational bit-reverse unit (din/funct -> res).
- Accepts operation requests over a valid/ready handshake and buffers them in a small FIFO.
- Decodes a 4-bit opcode into the reverse unit's 3-bit funct and tags illegal opcodes.
- Presents one operation per cycle to the reverse unit, with its result captured alongside m_valid by the consumer.

Parameters:
- DEPTH, 2, FIFO entries; power of two, >= 2.
- TAG_W, 4, width of the opaque request tag carried with each operation.
- CNT_W, 16, width of the statistics counters; counters saturate at all-ones.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; discards all buffered entries.
- s_valid  in  1  upstream request valid.
- s_ready  out  1  stage can accept this cycle.
- s_op  in  4  opcode: 0 pass, 1 rev2, 2 rev4, 3 rev8, 4 rev16, 5..15 illegal.
- s_data  in  32  operand.
- s_tag  in  TAG_W  request tag.
- m_valid  out  1  operation presented to the reverse unit.
- m_ready  in  1  downstream accepts.
- m_din  out  32  operand to the reverse unit.
- m_funct  out  3  funct to the reverse unit.
- m_tag  out  TAG_W  tag of the presented entry.
- m_illegal  out  1  presented entry carried an illegal opcode.
- illegal_cnt  out  CNT_W  count of accepted illegal opcodes.

Behaviour:
- Reset (rst_n low, async): FIFO empty, pointers 0, s_ready=1, m_valid=0, m_din=0, m_funct=0, m_tag=0, m_illegal=0, illegal_cnt=0.
- Push: s_valid && s_ready at a clock edge. Pop: m_valid && m_ready at a clock edge.
- s_ready = !full. It is derived from the registered occupancy only, never combinationally from m_ready.
- Decode at push time:
  - op 0..4 -> funct = op[2:0], illegal=0.
  - op 5..15 -> funct = 3'b111, illegal=1. The reverse unit then produces 32'hDEAD_BEEF.
  - Operand and tag are stored unmodified.
- m_valid = !empty. m_din, m_funct, m_tag and m_illegal come from the head entry and are held stable while m_valid && !m_ready.
- Latency: a push into an empty FIFO appears at m_valid the next cycle (1 cycle). There is no bypass path.
- Push and pop in the same cycle:
  - Not full: occupancy unchanged, order preserved.
  - Full: s_ready is already 0, so only the pop occurs. s_ready rises the following cycle.
  - Empty: only the push occurs.
- Pointers wrap modulo DEPTH. Occupancy is counted 0..DEPTH with a log2(DEPTH)+1 bit counter.
- illegal_cnt increments on each accepted push with an illegal op and saturates at 2^CNT_W-1. It is not cleared by flush.
- flush has priority over push and pop in the same cycle:
  - Occupancy goes to 0, m_valid=0 next cycle.
  - A concurrent push is dropped and not counted.
  - Output data registers are not cleared.
- Reset asserted mid-operation drops all entries immediately. m_valid deasserts asynchronously.
- Upstream must hold s_op/s_data/s_tag stable while s_valid && !s_ready. The stage does not check this.

Optional Feature:
- Macro ALU_RVS_ISSUE_STATS_EN.
- Defined: extra outputs accept_cnt and stall_cnt (both CNT_W, saturating, reset 0).
  - accept_cnt counts pushes.
  - stall_cnt counts cycles with m_valid && !m_ready.
- Undefined: neither port nor its logic exists. Everything else is unchanged.

Decomposition:
- Package alu_rvs_pkg holds:
  - opcode localparams OP_PASS=0, OP_REV2=1, OP_REV4=2, OP_REV8=3, OP_REV16=4;
  - FUNCT_ILLEGAL=3'b111;
  - ILLEGAL_RESULT=32'hDEAD_BEEF;
  - a decode function op->{illegal,funct}.
- One sub-module, alu_rvs_fifo: generic DEPTH x width synchronous FIFO with flush, full/empty and count.
- The issue stage instantiates alu_rvs_fifo and adds the decode and counters.

Test Plan:
- Reset, then push op=3, data=32'h0102_0304, tag=5 with m_ready=1 -> next cycle m_valid=1, m_funct=3, m_din=32'h0102_0304, m_tag=5, m_illegal=0; the reverse unit's result is 32'h8040_C020.
- Push op=9, data=32'h1234_5678 -> m_funct=7, m_illegal=1, illegal_cnt=1; the reverse unit's result is 32'hDEAD_BEEF.
- m_ready=0, push DEPTH=2 entries -> s_ready=0 after the second push. A third s_valid is not accepted. Raise m_ready -> entries drain in order, and s_ready=1 one cycle after the first pop.
- Occupancy 1, push and pop in the same cycle for 10 cycles with incrementing data -> output sequence matches input order, with no gaps or duplicates.
- Occupancy 2 plus simultaneous s_valid, flush=1 -> next cycle m_valid=0, s_ready=1, illegal_cnt unchanged, and the pushed entry never appears.
- Drive rst_n low between clock edges with occupancy 2 -> m_valid falls immediately. After release the FIFO is empty and illegal_cnt=0.
